// File: rtl/uart_rx_ctrl.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling FSM and a
// one-entry VALID/ACK holding register with sticky overrun.
module uart_rx_ctrl #(
    parameter int BIT_TMR_MAX = 10416,
    parameter int HALF_BIT    = BIT_TMR_MAX / 2,
    parameter int TMR_WIDTH   = 14
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RX,
    input  logic       ACK,
    output logic [7:0] DATA,
    output logic       VALID,
    output logic       OVERRUN,
    output logic       FRAME_ERR,
    output logic       BUSY
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    localparam logic [TMR_WIDTH-1:0] TMR_HALF = TMR_WIDTH'(HALF_BIT - 1);
    localparam logic [TMR_WIDTH-1:0] TMR_FULL = TMR_WIDTH'(BIT_TMR_MAX - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_sync1;
    logic                 r_sync2;
    logic                 w_rx_s;
    logic [TMR_WIDTH-1:0] r_tmr;
    logic [TMR_WIDTH-1:0] w_tmr_nxt;
    logic [2:0]           r_bit;
    logic [2:0]           w_bit_nxt;
    logic [7:0]           r_shift;
    logic [7:0]           w_shift_nxt;
    logic                 w_deliver;
    logic                 w_frame_err;
    logic [7:0]           r_data;
    logic                 r_valid;
    logic                 r_overrun;
    logic                 r_ferr;

    assign w_rx_s = r_sync2;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= RX;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_tmr   <= '0;
            r_bit   <= 3'd0;
            r_shift <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            r_tmr   <= w_tmr_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_tmr_nxt   = r_tmr + 1'b1;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_deliver   = 1'b0;
        w_frame_err = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_tmr_nxt = '0;
                if (!w_rx_s) begin
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (r_tmr == TMR_HALF) begin
                    w_tmr_nxt = '0;
                    if (w_rx_s) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_DATA;
                        w_bit_nxt   = 3'd0;
                    end
                end
            end
            S_DATA: begin
                if (r_tmr == TMR_FULL) begin
                    w_tmr_nxt   = '0;
                    w_shift_nxt = {w_rx_s, r_shift[7:1]};
                    w_bit_nxt   = r_bit + 3'd1;
                    if (r_bit == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (r_tmr == TMR_FULL) begin
                    w_tmr_nxt = '0;
                    if (w_rx_s) begin
                        w_deliver   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_frame_err = 1'b1;
                        w_state_nxt = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                // A line held low must rise before a new start bit counts.
                w_tmr_nxt = '0;
                if (w_rx_s) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_tmr_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_data    <= 8'h00;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            r_ferr <= w_frame_err;
            if (w_deliver) begin
                // Delivery wins over a same-cycle ACK: VALID stays set.
                r_data  <= r_shift;
                r_valid <= 1'b1;
                if (r_valid && !ACK) begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && ACK) begin
                r_valid   <= 1'b0;
                r_overrun <= 1'b0;
            end
        end
    end

    assign DATA      = r_data;
    assign VALID     = r_valid;
    assign OVERRUN   = r_overrun;
    assign FRAME_ERR = r_ferr;
    assign BUSY      = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl at 16 cycles per bit; expected bytes are queued
// when frames are driven and checked when the receiver delivers them.
module tb_uart_rx_ctrl;

    localparam int B = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic       ack = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic       overrun;
    logic       ferr;
    logic       busy;

    int         checks  = 0;
    int         errors  = 0;
    int         ferr_cnt = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_b;
    logic [7:0] last_data;

    uart_rx_ctrl #(
        .BIT_TMR_MAX(B),
        .HALF_BIT   (B / 2),
        .TMR_WIDTH  (4)
    ) dut (
        .CLK      (clk),
        .RST      (rst),
        .RX       (rx),
        .ACK      (ack),
        .DATA     (data),
        .VALID    (valid),
        .OVERRUN  (overrun),
        .FRAME_ERR(ferr),
        .BUSY     (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ferr) ferr_cnt++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                              input bit push);
        if (push) exp_q.push_back(b);
        rx = 1'b0;
        cyc(B);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            cyc(B);
        end
        rx = stop_bit;
        cyc(B);
    endtask

    task automatic pop_exp();
        if (exp_q.size() == 0) begin
            exp_b = 8'hxx;
        end else begin
            exp_b = exp_q.pop_front();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc(3);
        checks++;
        if ({data, valid, overrun, ferr, busy} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outs got %h/%b%b%b%b want 00/0000",
                     data, valid, overrun, ferr, busy);
        end
        rst = 1'b0;
        cyc(5);
        checks++;
        if (busy !== 1'b0 || valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle busy=%b valid=%b want 0 0",
                     busy, valid);
        end
    endtask

    task automatic test_single();
        int fe0;
        fe0 = ferr_cnt;
        fork
            send_frame(8'h55, 1'b1, 1'b1);
            begin
                cyc(154);
                checks++;
                if (valid !== 1'b0 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL single_pre valid=%b busy=%b want 0 1",
                             valid, busy);
                end
                cyc(1);
                checks++;
                if (valid !== 1'b1 || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL single_edge valid=%b busy=%b want 1 0",
                             valid, busy);
                end
                pop_exp();
                checks++;
                if (data !== exp_b) begin
                    errors++;
                    $display("FAIL single_data got %h want %h", data, exp_b);
                end
            end
        join
        checks++;
        if (ferr_cnt != fe0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL single_flags ferr=%0d ovr=%b want 0 0",
                     ferr_cnt - fe0, overrun);
        end
        ack = 1'b1;
        cyc(1);
        ack = 1'b0;
        checks++;
        if (valid !== 1'b0) begin
            errors++;
            $display("FAIL single_ack valid=%b want 0", valid);
        end
    endtask

    task automatic test_back_to_back();
        send_frame(8'hA3, 1'b1, 1'b1);
        pop_exp();
        checks++;
        if (data !== exp_b || valid !== 1'b1 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first got %h/%b%b want %h/10",
                     data, valid, overrun, exp_b);
        end
        send_frame(8'h0F, 1'b1, 1'b1);
        pop_exp();
        checks++;
        if (data !== exp_b || valid !== 1'b1 || overrun !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second got %h/%b%b want %h/11",
                     data, valid, overrun, exp_b);
        end
        last_data = exp_b;
        ack = 1'b1;
        cyc(1);
        ack = 1'b0;
        checks++;
        if (valid !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL b2b_ack valid=%b ovr=%b want 0 0",
                     valid, overrun);
        end
    endtask

    task automatic test_glitch();
        int fe0;
        fe0 = ferr_cnt;
        rx = 1'b0;
        cyc(5);
        rx = 1'b1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL glitch_start busy=%b want 1", busy);
        end
        cyc(20);
        checks++;
        if (busy !== 1'b0 || valid !== 1'b0 || ferr_cnt != fe0) begin
            errors++;
            $display("FAIL glitch_reject busy=%b valid=%b fe=%0d want 0 0 0",
                     busy, valid, ferr_cnt - fe0);
        end
    endtask

    task automatic test_frame_err();
        int fe0;
        bit fell;
        fe0 = ferr_cnt;
        send_frame(8'hC3, 1'b0, 1'b0);
        cyc(40);
        checks++;
        if (busy !== 1'b1 || ferr_cnt - fe0 != 1) begin
            errors++;
            $display("FAIL ferr_pulse busy=%b pulses=%0d want 1 1",
                     busy, ferr_cnt - fe0);
        end
        checks++;
        if (valid !== 1'b0 || data !== last_data) begin
            errors++;
            $display("FAIL ferr_hold got %h/%b want %h/0",
                     data, valid, last_data);
        end
        rx = 1'b1;
        fell = 1'b0;
        for (int i = 0; i < 10 && !fell; i++) begin
            cyc(1);
            if (busy === 1'b0) fell = 1'b1;
        end
        checks++;
        if (!fell) begin
            errors++;
            $display("FAIL ferr_release busy=%b want 0 within 10", busy);
        end
        cyc(200);
        checks++;
        if (valid !== 1'b0 || busy !== 1'b0 || ferr_cnt - fe0 != 1) begin
            errors++;
            $display("FAIL ferr_nosecond valid=%b busy=%b pulses=%0d",
                     valid, busy, ferr_cnt - fe0);
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] b;
        send_frame(8'h99, 1'b1, 1'b1);
        pop_exp();
        checks++;
        if (data !== exp_b || valid !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pre got %h/%b want %h/1",
                     data, valid, exp_b);
        end
        b = 8'h7E;
        rx = 1'b0;
        cyc(B);
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            cyc(B);
        end
        rx = b[4];
        cyc(8);
        rst = 1'b1;
        #2;
        checks++;
        if ({data, valid, overrun, ferr, busy} !== 12'h000) begin
            errors++;
            $display("FAIL rstmid_outs got %h/%b%b%b%b want 00/0000",
                     data, valid, overrun, ferr, busy);
        end
        cyc(1);
        rst = 1'b0;
        rx = 1'b1;
        cyc(20);
        send_frame(8'h31, 1'b1, 1'b1);
        pop_exp();
        checks++;
        if (data !== exp_b || valid !== 1'b1 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_after got %h/%b%b want %h/10",
                     data, valid, overrun, exp_b);
        end
    endtask

    task automatic test_ack_same_cycle();
        fork
            send_frame(8'h42, 1'b1, 1'b1);
            begin
                cyc(154);
                ack = 1'b1;
                cyc(1);
                ack = 1'b0;
            end
        join
        pop_exp();
        checks++;
        if (data !== exp_b || valid !== 1'b1 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL ackdeliv got %h/%b%b want %h/10",
                     data, valid, overrun, exp_b);
        end
    endtask

    task automatic test_ack_hold();
        ack = 1'b1;
        cyc(3);
        ack = 1'b0;
        checks++;
        if (valid !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL ackhold valid=%b ovr=%b want 0 0",
                     valid, overrun);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_empty left=%0d want 0", exp_q.size());
        end
    endtask

    initial begin
        last_data = 8'h00;
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_reset_midframe();
        test_ack_same_cycle();
        test_ack_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
